// File: rtl/masker_ctrl_pkg.sv
// Shared constants for the FrameLink masker configuration controller:
// MI register map, CTRL bit positions and mask word-count helper.
package masker_ctrl_pkg;

    localparam logic [5:0] CTRL_ADDR = 6'h20;
    localparam logic [5:0] CNT_ADDR  = 6'h21;

    localparam int CTRL_COMMIT_BIT   = 0;
    localparam int CTRL_PENDING_BIT  = 0;
    localparam int CTRL_IN_FRAME_BIT = 1;

    function automatic int mask_words(input int mask_width);
        return mask_width / 32;
    endfunction

endpackage

// File: rtl/fl_frame_tracker.sv
// Snoops the masker RX FrameLink and reports word transfers, boundary
// events and whether a frame is currently open.
module fl_frame_tracker (
    input  logic clk,
    input  logic reset,
    input  logic sof_n,
    input  logic eof_n,
    input  logic src_rdy_n,
    input  logic dst_rdy_n,
    output logic xfer,
    output logic sof_xfer,
    output logic eof_xfer,
    output logic in_frame
);

    assign xfer     = !src_rdy_n & !dst_rdy_n;
    assign sof_xfer = xfer & !sof_n;
    assign eof_xfer = xfer & !eof_n;

    // EOF wins so a single-word frame never leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset)         in_frame <= 1'b0;
        else if (eof_xfer) in_frame <= 1'b0;
        else if (sof_xfer) in_frame <= 1'b1;
    end

endmodule

// File: rtl/fl_masker_ctrl.sv
// Shadow/active mask controller: MI32-writable shadow committed to MASK only
// at a frame boundary. Define FL_MASKER_CTRL_RDBACK_EN to enable shadow readback.
module fl_masker_ctrl
    import masker_ctrl_pkg::*;
#(
    parameter  int FL_WIDTH        = 128,
    parameter  int NUMBER_OF_WORDS = 4,
    localparam int MASK_WIDTH      = NUMBER_OF_WORDS * FL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           MI_DWR,
    input  logic [31:0]           MI_ADDR,
    input  logic                  MI_RD,
    input  logic                  MI_WR,
    output logic                  MI_ARDY,
    output logic [31:0]           MI_DRD,
    output logic                  MI_DRDY,
    input  logic                  FL_SOF_N,
    input  logic                  FL_EOF_N,
    input  logic                  FL_SRC_RDY_N,
    input  logic                  FL_DST_RDY_N,
    output logic [MASK_WIDTH-1:0] MASK,
    output logic                  PENDING
);

    localparam int         NW   = mask_words(MASK_WIDTH);
    localparam int         IW   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [6:0] NW_L = 7'(NW);

    logic [NW-1:0][31:0] shadow, mask_q;
    logic        pending;
    logic [15:0] cnt;
    logic        sof_xfer, eof_xfer, in_frame, unused_xfer;
    logic [5:0]  idx;
    logic [IW-1:0] widx;
    logic        is_shadow, wr_en, rd_en, commit_req, swap;
    logic [31:0] rd_data;
    logic        unused_addr;

    fl_frame_tracker u_tracker (
        .clk       (CLK),
        .reset     (RESET),
        .sof_n     (FL_SOF_N),
        .eof_n     (FL_EOF_N),
        .src_rdy_n (FL_SRC_RDY_N),
        .dst_rdy_n (FL_DST_RDY_N),
        .xfer      (unused_xfer),
        .sof_xfer  (sof_xfer),
        .eof_xfer  (eof_xfer),
        .in_frame  (in_frame)
    );

    assign unused_addr = ^{MI_ADDR[31:8], MI_ADDR[1:0]};
    assign idx         = MI_ADDR[7:2];
    assign widx        = idx[IW-1:0];
    assign is_shadow   = {1'b0, idx} < NW_L;

    // Shadow writes stall while a commit waits, so the swapped image is stable.
    assign wr_en      = MI_WR & !(pending & is_shadow);
    assign rd_en      = MI_RD & !MI_WR;
    assign MI_ARDY    = MI_RD | wr_en;
    assign commit_req = wr_en & (idx == CTRL_ADDR) & MI_DWR[CTRL_COMMIT_BIT];
    assign swap       = pending & ((!in_frame & !sof_xfer) | eof_xfer);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow  <= '1;
            mask_q  <= '1;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            if (wr_en & is_shadow) shadow[widx] <= MI_DWR;
            if (swap) begin
                mask_q <= shadow;
                cnt    <= cnt + 16'd1;
            end
            pending <= pending ? !swap : commit_req;
        end
    end

    always_comb begin
        rd_data = '0;
        if (is_shadow) begin
`ifdef FL_MASKER_CTRL_RDBACK_EN
            rd_data = shadow[widx];
`endif
        end else if (idx == CTRL_ADDR) begin
            rd_data[CTRL_PENDING_BIT]  = pending;
            rd_data[CTRL_IN_FRAME_BIT] = in_frame;
        end else if (idx == CNT_ADDR) begin
            rd_data = {16'd0, cnt};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MI_DRD  <= '0;
            MI_DRDY <= 1'b0;
        end else begin
            MI_DRDY <= rd_en;
            if (rd_en) MI_DRD <= rd_data;
        end
    end

    assign MASK    = mask_q;
    assign PENDING = pending;

endmodule
